// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, x/y counters, sync/blank decode
// and a configurable delay line that lines timing up with a pipelined renderer.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 1,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic          vga_clk,
  output logic [XW-1:0] pixelx,
  output logic [YW-1:0] pixely,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  // PIPE_DLY=0 still needs one output register, fed from the next counter state
  localparam int NST     = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 2");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end
  if (XW < 1 || XW > 30 || (H_TOTAL - 1) >= (1 << XW)) begin : g_bad_xw
    $error("vga_timing_gen: XW too small for H_TOTAL-1");
  end
  if (YW < 1 || YW > 30 || (V_TOTAL - 1) >= (1 << YW)) begin : g_bad_yw
    $error("vga_timing_gen: YW too small for V_TOTAL-1");
  end

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tim_t;

  localparam tim_t TIM_IDLE = {1'b0, ~HS_POL, ~VS_POL};

  function automatic tim_t decode(input int x, input int y);
    tim_t t;
    t.act = (x < H_ACTIVE) && (y < V_ACTIVE);
    t.hs  = ((x >= HS_BEG) && (x <= HS_END)) ? HS_POL : ~HS_POL;
    t.vs  = ((y >= VS_BEG) && (y <= VS_END)) ? VS_POL : ~VS_POL;
    return t;
  endfunction

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          x_wrap;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  tim_t          tim_src;
  tim_t          tim_p [NST];

  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
  assign pix_en  = en && (div_cnt == DIV_LAST);

  // vga_clk tracks div_cnt so its rising edge lands mid-pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else if (en) begin
      div_cnt <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

  assign x_wrap = (pixelx == X_LAST);
  assign x_nxt  = x_wrap ? '0 : pixelx + XW'(1);
  assign y_nxt  = !x_wrap ? pixely : ((pixely == Y_LAST) ? '0 : pixely + YW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixelx <= '0;
      pixely <= '0;
    end else if (pix_en) begin
      pixelx <= x_nxt;
      pixely <= y_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && x_wrap;
      frame_start <= pix_en && x_wrap && (pixely == Y_LAST);
    end
  end

  // Stage p0: decode of the counter position the delay line is sampling
  assign tim_src = (PIPE_DLY == 0) ? decode(int'(x_nxt), int'(y_nxt))
                                   : decode(int'(pixelx), int'(pixely));

  // Stages p0..pN-1: shift on each pixel tick; last stage drives the DAC pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NST; i++) tim_p[i] <= TIM_IDLE;
    end else if (pix_en) begin
      tim_p[0] <= tim_src;
      for (int i = 1; i < NST; i++) tim_p[i] <= tim_p[i-1];
    end
  end

  assign active = tim_p[NST-1].act;
  assign blank  = tim_p[NST-1].act;
  assign hsync  = tim_p[NST-1].hs;
  assign vsync  = tim_p[NST-1].vs;
  assign sync   = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 clock-divider/synchronizer pair.
- Generates the pixel-rate enable, the DAC pixel clock, the pixel coordinates and all VGA timing strobes from the one system clock.
- Resolution, porches, sync polarity, clock division ratio and renderer pipeline compensation are all configurable.
- Sits between the board clock and the renderer. Its outputs drive the DAC directly: hsync, vsync, blank, sync, vga_clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- CLK_DIV, 2, system clocks per pixel (must be >= 2)
- PIPE_DLY, 1, pixel ticks by which timing outputs lag the coordinates (0..7)
- XW, 10, width of pixelx (must hold H_TOTAL-1)
- YW, 10, width of pixely (must hold V_TOTAL-1)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-low reset
- en, in, 1, run enable; low freezes all timing state
- pix_en, out, 1, one-clk pixel tick strobe
- vga_clk, out, 1, registered pixel clock to the DAC
- pixelx, out, XW, current horizontal count
- pixely, out, YW, current vertical count
- active, out, 1, visible-region flag (delayed)
- hsync, out, 1, horizontal sync (delayed, polarity HS_POL)
- vsync, out, 1, vertical sync (delayed, polarity VS_POL)
- blank, out, 1, DAC blank_n: 1 in the visible region (delayed)
- sync, out, 1, DAC composite sync_n, constant 0
- line_start, out, 1, one-clk pulse when pixelx becomes 0
- frame_start, out, 1, one-clk pulse when pixelx and pixely both become 0

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (rst=0, asynchronous):
  - div_cnt, pixelx, pixely = 0.
  - pix_en, vga_clk, active, blank, line_start, frame_start = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - All delay-line stages load these inactive values.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - pix_en = 1 for exactly the clk in which div_cnt == CLK_DIV-1.
  - vga_clk is registered: 1 while div_cnt >= CLK_DIV/2, else 0. Its rising edge therefore falls mid-pixel, after the outputs update.
- Counters, advancing only on a clk edge with pix_en=1:
  - pixelx increments.
  - At pixelx == H_TOTAL-1, pixelx wraps to 0 and pixely increments.
  - At pixely == V_TOTAL-1 together with the pixelx wrap, pixely wraps to 0.
- Decode, from the undelayed counters:
  - act = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hs asserted for H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1.
  - vs asserted for V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1. vs depends on the line only.
- Delay line:
  - {act, hs, vs} passes through a PIPE_DLY-stage shift register that advances only on pix_en.
  - Outputs are registered, so at the pixel whose coordinates are (x, y), active/hsync/vsync/blank reflect pixel position PIPE_DLY ticks earlier.
  - PIPE_DLY=0: registered decode of the current counters, updating on the same edge as pixelx.
  - blank = active, always.
- Strobes:
  - line_start = 1 for one clk, on the clk following the edge where pixelx wrapped to 0.
  - frame_start = 1 likewise, when pixely also wrapped to 0.
  - No strobe is issued on reset release; the first frame_start comes at the end of the first full frame.
- en=0:
  - div_cnt, counters, delay line, vga_clk and all outputs hold; pix_en is forced 0; strobes deassert after one clk.
  - When en returns to 1, counting resumes from the held div_cnt with no skipped or duplicated pixel.
- Reset mid-frame: all state returns immediately to reset values; counting restarts at (0,0) after rst deasserts.
- sync is constant 0.
- Parameter checks: out-of-range CLK_DIV, PIPE_DLY, XW or YW is a $error at elaboration.

Test Plan:
- Defaults, run 2 frames:
  - H_TOTAL 800, V_TOTAL 525; frame_start pulses exactly 840000 clks apart.
  - pix_en duty 1/2; vga_clk period 2 clks.
- Defaults, horizontal timing: with PIPE_DLY=1, hsync=0 for exactly 96 pix ticks per line. It falls one tick after pixelx becomes 656 and rises one tick after pixelx becomes 752. blank is high for 640 ticks per visible line.
- Defaults, vertical timing: vsync=0 for 2 lines, covering lines 490..491 delayed by 1 tick. blank=0 throughout lines 480..524.
- en deasserted at pixelx=100, pixely=7 for 37 clks: pixelx, pixely, div_cnt and all outputs frozen, pix_en=0. After re-enable, next pixelx=101 and the line length is still 800 ticks.
- rst pulsed low at pixelx=400, pixely=300:
  - All outputs take reset values asynchronously (hsync=vsync=1).
  - After release, pixelx counts from 0 and the first frame_start arrives 840000 clks later.
- Override H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=3, HS_POL=1, VS_POL=1, PIPE_DLY=0:
  - Frame of 8x6 pixels = 144 clks.
  - hsync=1 at pixelx 5..6; vsync=1 on line 4.
  - vga_clk high 2 of every 3 clks (div_cnt 1..2).
